// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator.
package calc_pkg;

  localparam int unsigned W_OP_DEF    = 8;
  localparam int unsigned W_RES_DEF   = 16;
  localparam int unsigned TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    CAPT  = 3'd0,
    OPSEL = 3'd1,
    EXEC  = 3'd2,
    SHOW  = 3'd3,
    ERR   = 3'd4
  } estado_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10
  } op_t;

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_MUL = 4'hC;
  localparam logic [3:0] K_CLR = 4'hF;

  // Map an operator key to its arithmetic opcode (non-operator keys fall back to add).
  function automatic op_t key_to_op(input logic [3:0] k);
    case (k)
      K_SUB:   return OP_SUB;
      K_MUL:   return OP_MUL;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/contador_timeout.sv
// Cycle counter for the EXEC wait; expire_c flags the last allowed cycle.
module contador_timeout #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;

  // Restart from zero on load, otherwise count while enabled and stop at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && !expire_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_c = en && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/secuenciador_calculadora.sv
// Top-level sequencer: operand capture, operator decode, launch, wait and result hold.
module secuenciador_calculadora
  import calc_pkg::*;
#(
  parameter int unsigned W_OP    = W_OP_DEF,
  parameter int unsigned W_RES   = W_RES_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       tecla,
  input  logic             tecla_valida,
  output logic             cap_tecla_valida,
  output logic             cap_clr,
  input  logic             ready_operands,
  input  logic [W_OP-1:0]  A_bin,
  input  logic [W_OP-1:0]  B_bin,
  output logic             op_start,
  output logic [1:0]       op_code,
  output logic [W_OP-1:0]  op_a,
  output logic [W_OP-1:0]  op_b,
  input  logic             op_done,
  input  logic [W_RES-1:0] op_result,
  output logic [W_RES-1:0] result,
  output logic             result_valid,
  output logic             error,
  output logic [2:0]       estado
);

  estado_t          state_q, state_d;
  op_t              op_code_q, op_code_d;
  logic [W_OP-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
  logic [W_RES-1:0] result_q, result_d;
  logic             cap_clr_q, cap_clr_d;
  logic             op_start_q, op_start_d;
  logic             result_valid_q, result_valid_d;
  logic             error_q, error_d;
  logic             started_q;
  logic             cnt_load, cnt_en, expire_c;

  contador_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .expire_c (expire_c)
  );

  // State and registered outputs; started_q marks the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= CAPT;
      op_code_q      <= OP_ADD;
      op_a_q         <= '0;
      op_b_q         <= '0;
      result_q       <= '0;
      cap_clr_q      <= 1'b0;
      op_start_q     <= 1'b0;
      result_valid_q <= 1'b0;
      error_q        <= 1'b0;
      started_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_code_q      <= op_code_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      result_q       <= result_d;
      cap_clr_q      <= cap_clr_d;
      op_start_q     <= op_start_d;
      result_valid_q <= result_valid_d;
      error_q        <= error_d;
      started_q      <= 1'b1;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d        = state_q;
    op_code_d      = op_code_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    result_d       = result_q;
    cap_clr_d      = !started_q;
    op_start_d     = 1'b0;
    result_valid_d = 1'b0;
    error_d        = 1'b0;
    cnt_load       = 1'b0;
    cnt_en         = 1'b0;

    case (state_q)
      CAPT: begin
        // Ignore a stale ready while the capture block is still being cleared.
        if (started_q && !cap_clr_q && ready_operands) state_d = OPSEL;
      end
      OPSEL: begin
        if (tecla_valida) begin
          case (tecla)
            K_ADD, K_SUB, K_MUL: begin
              op_code_d  = key_to_op(tecla);
              op_a_d     = A_bin;
              op_b_d     = B_bin;
              op_start_d = 1'b1;
              cnt_load   = 1'b1;
              state_d    = EXEC;
            end
            K_CLR: begin
              cap_clr_d = 1'b1;
              state_d   = CAPT;
            end
            default: begin
              error_d = 1'b1;
              state_d = ERR;
            end
          endcase
        end
      end
      EXEC: begin
        cnt_en = 1'b1;
        // A completion on the timeout cycle still counts as success.
        if (op_done) begin
          result_d       = op_result;
          result_valid_d = 1'b1;
          state_d        = SHOW;
        end else if (expire_c) begin
          error_d = 1'b1;
          state_d = ERR;
        end
      end
      SHOW: begin
        result_valid_d = 1'b1;
        if (tecla_valida) begin
          cap_clr_d      = 1'b1;
          result_valid_d = 1'b0;
          state_d        = CAPT;
        end
      end
      ERR: begin
        error_d = 1'b1;
        if (tecla_valida) begin
          cap_clr_d = 1'b1;
          error_d   = 1'b0;
          state_d   = CAPT;
        end
      end
      default: state_d = CAPT;
    endcase
  end

  // Key strobes reach the capture block only in CAPT and never alongside a clear.
  assign cap_tecla_valida = tecla_valida && (state_q == CAPT) && started_q && !cap_clr_q;

  assign cap_clr      = cap_clr_q;
  assign op_start     = op_start_q;
  assign op_code      = op_code_q;
  assign op_a         = op_a_q;
  assign op_b         = op_b_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign error        = error_q;
  assign estado       = state_q;

endmodule

// File: tb/tb_secuenciador_calculadora.sv
// Self-checking bench: directed scenarios plus randomized transactions vs a key-level model.
module tb_secuenciador_calculadora;

  localparam int unsigned W_OP    = 8;
  localparam int unsigned W_RES   = 16;
  localparam int unsigned TIMEOUT = 1024;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       tecla;
  logic             tecla_valida;
  logic             cap_tecla_valida;
  logic             cap_clr;
  logic             ready_operands = 1'b0;
  logic [W_OP-1:0]  A_bin, B_bin;
  logic             op_start;
  logic [1:0]       op_code;
  logic [W_OP-1:0]  op_a, op_b;
  logic             op_done;
  logic [W_RES-1:0] op_result;
  logic [W_RES-1:0] result;
  logic             result_valid;
  logic             error;
  logic [2:0]       estado;

  int n_chk  = 0;
  int n_pass = 0;

  secuenciador_calculadora #(.W_OP(W_OP), .W_RES(W_RES), .TIMEOUT(TIMEOUT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tecla            (tecla),
    .tecla_valida     (tecla_valida),
    .cap_tecla_valida (cap_tecla_valida),
    .cap_clr          (cap_clr),
    .ready_operands   (ready_operands),
    .A_bin            (A_bin),
    .B_bin            (B_bin),
    .op_start         (op_start),
    .op_code          (op_code),
    .op_a             (op_a),
    .op_b             (op_b),
    .op_done          (op_done),
    .op_result        (op_result),
    .result           (result),
    .result_valid     (result_valid),
    .error            (error),
    .estado           (estado)
  );

  always #5 clk = ~clk;

  // Capture block stand-in: four hex keys, A = first two nibbles, B = last two.
  logic [15:0] cap_sh  = '0;
  int          cap_cnt = 0;
  always @(posedge clk) begin
    if (cap_clr) begin
      cap_sh         <= '0;
      cap_cnt        <= 0;
      ready_operands <= 1'b0;
    end else if (cap_tecla_valida && cap_cnt < 4) begin
      cap_sh  <= {cap_sh[11:0], tecla};
      cap_cnt <= cap_cnt + 1;
      if (cap_cnt == 3) ready_operands <= 1'b1;
    end
  end
  assign A_bin = cap_sh[15:8];
  assign B_bin = cap_sh[7:0];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    tecla        = k;
    tecla_valida = 1'b1;
    tick();
    tecla_valida = 1'b0;
  endtask

  task automatic enter_digits(input int d0, input int d1, input int d2, input int d3);
    tick();
    press(4'(d0)); tick();
    press(4'(d1)); tick();
    press(4'(d2)); tick();
    press(4'(d3)); tick();
    chk("opsel_after_digits", 32'(estado), 32'd1);
  endtask

  // Arithmetic the external unit would perform, expressed on plain integers.
  function automatic logic [15:0] model_res(input int op, input int a, input int b);
    case (op)
      0:       return 16'(a + b);
      1:       return 16'(a - b);
      default: return 16'(a * b);
    endcase
  endfunction

  initial begin
    int d[4];
    int op, a, b, dly;
    logic [15:0] exp_res;

    rst_n = 1'b0; tecla = '0; tecla_valida = 1'b0; op_done = 1'b0; op_result = '0;
    repeat (3) tick();
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_cap_clr", 32'(cap_clr), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", {29'd0, op_start, result_valid, error}, 32'd0);

    rst_n = 1'b1;
    tick();
    chk("first_cap_clr", 32'(cap_clr), 32'd1);
    tick();
    chk("cap_clr_drop", 32'(cap_clr), 32'd0);

    // Add: 4,2,0,8 -> A=0x42, B=0x08
    enter_digits(4, 2, 0, 8);
    press(4'hA);
    chk("add_op_start", 32'(op_start), 32'd1);
    chk("add_op_a", 32'(op_a), 32'd66);
    chk("add_op_b", 32'(op_b), 32'd8);
    chk("add_op_code", 32'(op_code), 32'd0);
    chk("add_estado", 32'(estado), 32'd2);
    tick();
    chk("add_op_start_pulse", 32'(op_start), 32'd0);
    tick(); tick();
    op_done = 1'b1; op_result = 16'd74;
    tick();
    op_done = 1'b0;
    chk("add_result", 32'(result), 32'd74);
    chk("add_result_valid", 32'(result_valid), 32'd1);
    repeat (3) tick();
    chk("add_result_hold", 32'(result_valid), 32'd1);
    press(4'h1);
    chk("show_clr", 32'(cap_clr), 32'd1);
    chk("show_valid_drop", 32'(result_valid), 32'd0);
    chk("show_to_capt", 32'(estado), 32'd0);

    // Mul: 5,0,0,3 -> 0x50 * 3
    enter_digits(5, 0, 0, 3);
    press(4'hC);
    chk("mul_op_code", 32'(op_code), 32'd2);
    chk("mul_op_a", 32'(op_a), 32'd80);
    chk("mul_op_b", 32'(op_b), 32'd3);
    op_done = 1'b1; op_result = 16'h00F0;
    tick();
    op_done = 1'b0;
    chk("mul_result", 32'(result), 32'd240);
    press(4'h0);
    chk("mul_clear", 32'(estado), 32'd0);

    // Bad operator key
    enter_digits(1, 1, 1, 1);
    press(4'h7);
    chk("bad_error", 32'(error), 32'd1);
    chk("bad_estado", 32'(estado), 32'd4);
    chk("bad_no_start", 32'(op_start), 32'd0);
    tick();
    chk("bad_error_hold", {31'd0, error | op_start}, 32'd1);
    press(4'h3);
    chk("bad_clr", 32'(cap_clr), 32'd1);
    chk("bad_error_drop", 32'(error), 32'd0);
    chk("bad_to_capt", 32'(estado), 32'd0);

    // Timeout with op_done withheld
    enter_digits(9, 9, 0, 1);
    press(4'hB);
    chk("to_op_start", 32'(op_start), 32'd1);
    repeat (TIMEOUT - 1) tick();
    chk("to_not_yet", 32'(error), 32'd0);
    chk("to_still_exec", 32'(estado), 32'd2);
    tick();
    chk("to_error", 32'(error), 32'd1);
    chk("to_estado", 32'(estado), 32'd4);
    press(4'h0);

    // Done on the timeout boundary cycle wins
    enter_digits(1, 2, 3, 4);
    press(4'hB);
    exp_res = model_res(1, 18, 52);
    repeat (TIMEOUT - 1) tick();
    op_done = 1'b1; op_result = exp_res;
    tick();
    op_done = 1'b0;
    chk("bnd_estado", 32'(estado), 32'd3);
    chk("bnd_error", 32'(error), 32'd0);
    chk("bnd_sub_result", 32'(result), 32'h0000FFDE);
    press(4'h2);

    // Reset during EXEC
    enter_digits(3, 3, 2, 2);
    press(4'hA);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_estado", 32'(estado), 32'd0);
    chk("mid_rst_ops", {op_a, op_b, 14'd0, op_code}, 32'd0);
    chk("mid_rst_flags", {28'd0, op_start, result_valid, error, cap_clr}, 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    tick();
    rst_n = 1'b1;
    op_done = 1'b1; op_result = 16'h1234;
    tick();
    op_done = 1'b0;
    chk("late_done_ignored", 32'(result_valid), 32'd0);
    chk("late_done_estado", 32'(estado), 32'd0);
    tick();
    chk("late_done_result", 32'(result), 32'd0);

    // Randomized transactions
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 4; j++) d[j] = int'($urandom_range(0, 15));
      op  = int'($urandom_range(0, 2));
      a   = d[0] * 16 + d[1];
      b   = d[2] * 16 + d[3];
      exp_res = model_res(op, a, b);
      enter_digits(d[0], d[1], d[2], d[3]);
      press(4'(10 + op));
      chk("rnd_op_start", 32'(op_start), 32'd1);
      chk("rnd_op_code", 32'(op_code), 32'(op));
      chk("rnd_op_a", 32'(op_a), 32'(a));
      chk("rnd_op_b", 32'(op_b), 32'(b));
      dly = int'($urandom_range(0, 6));
      repeat (dly) tick();
      op_done = 1'b1; op_result = exp_res;
      tick();
      op_done = 1'b0;
      chk("rnd_result", 32'(result), 32'(exp_res));
      chk("rnd_result_valid", 32'(result_valid), 32'd1);
      press(4'($urandom_range(0, 15)));
      chk("rnd_clear", 32'(estado), 32'd0);
    end

    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
